// File: rtl/datapath.sv
// rtl/datapath.sv - single-bus 32-bit CPU datapath: PC/IR/MAR/MDR/Y/HI/LO/Z, R2/R4/R5 and ALU.
// Optional build macro DIV_EN adds the signed divider behind the DIV select.
module datapath #(
  parameter int WIDTH = 32
) (
  input  logic                          Clock,
  input  logic                          Clear,
  output logic signed [2*WIDTH-1:0]     outp,
  input  logic                          PCout,
  input  logic                          Zhiout,
  input  logic                          Zlowout,
  input  logic                          MDRout,
  input  logic                          R2out,
  input  logic                          R4out,
  input  logic                          HIout,
  input  logic                          LOout,
  input  logic                          MARin,
  input  logic                          Zin,
  input  logic                          PCin,
  input  logic                          MDRin,
  input  logic                          IRin,
  input  logic                          Yin,
  input  logic                          HIin,
  input  logic                          LOin,
  input  logic                          IncPC,
  input  logic                          Read,
  input  logic                          R5in,
  input  logic                          R2in,
  input  logic                          R4in,
  input  logic [WIDTH-1:0]              Mdatain,
  input  logic                          AND,
  input  logic                          OR,
  input  logic                          ADD,
  input  logic                          SUB,
  input  logic                          MUL,
  input  logic                          DIV,
  input  logic                          SHR,
  input  logic                          SHL,
  input  logic                          ROR,
  input  logic                          ROL,
  input  logic                          NEG,
  input  logic                          NOT
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]   pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, lo_q, r2_q, r4_q, r5_q;
  logic [2*WIDTH-1:0] z_q;
  logic [WIDTH-1:0]   bus;
  logic [WIDTH-1:0]   alu_lo, alu_hi;
  logic [4:0]         sh, sh_n;
  logic signed [2*WIDTH-1:0] prod;
  logic               unused_ok;

  // Fixed-priority bus source mux; idle bus reads as zero.
  always_comb begin
    bus = '0;
    if (MDRout)       bus = mdr_q;
    else if (PCout)   bus = pc_q;
    else if (Zlowout) bus = z_q[WIDTH-1:0];
    else if (Zhiout)  bus = z_q[2*WIDTH-1:WIDTH];
    else if (HIout)   bus = hi_q;
    else if (LOout)   bus = lo_q;
    else if (R2out)   bus = r2_q;
    else if (R4out)   bus = r4_q;
  end

  assign sh   = bus[4:0];
  assign sh_n = 5'd0 - sh;
  assign prod = $signed({{WIDTH{y_q[WIDTH-1]}}, y_q}) * $signed({{WIDTH{bus[WIDTH-1]}}, bus});

`ifdef DIV_EN
  logic signed [WIDTH-1:0] quo, rem;
  always_comb begin
    quo = '1;
    rem = y_q;
    if (bus != '0) begin
      quo = $signed(y_q) / $signed(bus);
      rem = $signed(y_q) % $signed(bus);
    end
  end
`endif

  always_comb begin
    alu_hi = '0;
    alu_lo = bus;
    if (IncPC)    alu_lo = bus + ONE;
    else if (AND) alu_lo = y_q & bus;
    else if (OR)  alu_lo = y_q | bus;
    else if (ADD) alu_lo = y_q + bus;
    else if (SUB) alu_lo = y_q - bus;
    else if (MUL) {alu_hi, alu_lo} = prod;
    else if (DIV) begin
`ifdef DIV_EN
      alu_hi = rem;
      alu_lo = quo;
`else
      alu_lo = bus;
`endif
    end
    else if (SHR) alu_lo = y_q >> sh;
    else if (SHL) alu_lo = y_q << sh;
    else if (ROR) alu_lo = (y_q >> sh) | (y_q << sh_n);
    else if (ROL) alu_lo = (y_q << sh) | (y_q >> sh_n);
    else if (NEG) alu_lo = '0 - bus;
    else if (NOT) alu_lo = ~bus;
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      r2_q  <= '0;
      r4_q  <= '0;
      r5_q  <= '0;
      z_q   <= '0;
    end else begin
      if (PCin)  pc_q  <= bus;
      if (IRin)  ir_q  <= bus;
      if (MARin) mar_q <= bus;
      if (MDRin) mdr_q <= Read ? Mdatain : bus;
      if (Yin)   y_q   <= bus;
      if (HIin)  hi_q  <= bus;
      if (LOin)  lo_q  <= bus;
      if (R2in)  r2_q  <= bus;
      if (R4in)  r4_q  <= bus;
      if (R5in)  r5_q  <= bus;
      if (Zin)   z_q   <= {alu_hi, alu_lo};
    end
  end

  // IR, MAR and R5 have no consumer inside the datapath.
  assign unused_ok = ^{ir_q, mar_q, r5_q};
  assign outp      = z_q;

endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - randomized self-checking bench for datapath against a behavioural model.
module tb_datapath;

  logic        Clock = 1'b0;
  logic        Clear;
  logic signed [63:0] outp;
  logic PCout, Zhiout, Zlowout, MDRout, R2out, R4out, HIout, LOout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, IncPC, Read, R5in, R2in, R4in;
  logic [31:0] Mdatain;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT;

  int errors = 0;
  int checks = 0;

  datapath #(.WIDTH(32)) dut (
    .Clock(Clock), .Clear(Clear), .outp(outp),
    .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
    .R2out(R2out), .R4out(R4out), .HIout(HIout), .LOout(LOout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
    .R5in(R5in), .R2in(R2in), .R4in(R4in), .Mdatain(Mdatain),
    .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV),
    .SHR(SHR), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr_ctl();
    {PCout, Zhiout, Zlowout, MDRout, R2out, R4out, HIout, LOout} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, IncPC, Read, R5in, R2in, R4in} = '0;
    {AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT} = '0;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
    clr_ctl();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1'b1; MDRin = 1'b1;
    step();
  endtask

  task automatic set_y(input logic [31:0] v);
    load_mdr(v);
    MDRout = 1'b1; Yin = 1'b1;
    step();
  endtask

  // op codes: 0 none, 1 inc, 2 and, 3 or, 4 add, 5 sub, 6 mul, 7 div, 8 shr, 9 shl, 10 ror, 11 rol, 12 neg, 13 not
  task automatic set_op(input int op);
    case (op)
      1: IncPC = 1'b1;  2: AND = 1'b1;  3: OR = 1'b1;   4: ADD = 1'b1;
      5: SUB = 1'b1;    6: MUL = 1'b1;  7: DIV = 1'b1;  8: SHR = 1'b1;
      9: SHL = 1'b1;   10: ROR = 1'b1; 11: ROL = 1'b1; 12: NEG = 1'b1;
      13: NOT = 1'b1;
      default: ;
    endcase
  endtask

  task automatic run_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    set_y(a);
    load_mdr(b);
    MDRout = 1'b1; Zin = 1'b1;
    set_op(op);
    step();
  endtask

  function automatic logic [63:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    longint p;
    int s;
    s = int'(b % 32);
    r = a;
    case (op)
      1:  return {32'd0, b + 32'd1};
      2:  return {32'd0, a & b};
      3:  return {32'd0, a | b};
      4:  return {32'd0, a + b};
      5:  return {32'd0, a - b};
      6: begin
        p = longint'(int'($signed(a))) * longint'(int'($signed(b)));
        return p;
      end
      7: begin
`ifdef DIV_EN
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {32'(int'($signed(a)) % int'($signed(b))), 32'(int'($signed(a)) / int'($signed(b)))};
`else
        return {32'd0, b};
`endif
      end
      8:  return 64'(a) / (64'd1 << s);
      9:  return {32'd0, 32'(64'(a) * (64'd1 << s))};
      10: begin
        repeat (s) r = {r[0], r[31:1]};
        return {32'd0, r};
      end
      11: begin
        repeat (s) r = {r[30:0], r[31]};
        return {32'd0, r};
      end
      12: return {32'd0, 32'd0 - b};
      13: return {32'd0, ~b};
      default: return {32'd0, b};
    endcase
  endfunction

  logic [31:0] src[8];
  logic [63:0] z_m;
  logic [31:0] a_r, b_r, bus_m;
  int op_r;
  logic [7:0] mask;

  initial begin
    clr_ctl();
    Mdatain = '0;
    Clear = 1'b1;
    #1;
    check("reset_outp", outp, 64'd0);
    check("reset_pc", dut.pc_q, 64'd0);
    @(posedge Clock); #1;
    Clear = 1'b0;

    load_mdr(32'd12); MDRout = 1; R2in = 1; step();
    load_mdr(32'd15); MDRout = 1; R4in = 1; step();
    load_mdr(32'd10); MDRout = 1; R5in = 1; step();
    check("r2_load", dut.r2_q, 64'd12);
    check("r4_load", dut.r4_q, 64'd15);
    check("r5_load", dut.r5_q, 64'd10);
    check("mdr_hold", dut.mdr_q, 64'd10);

    PCout = 1; MARin = 1; IncPC = 1; Zin = 1; step();
    check("fetch_mar", dut.mar_q, 64'd0);
    check("fetch_z", outp, 64'd1);
    Mdatain = 32'h1A920000; Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; step();
    check("fetch_pc", dut.pc_q, 64'd1);
    MDRout = 1; IRin = 1; step();
    check("fetch_ir", dut.ir_q, 64'h1A920000);

    R2out = 1; Yin = 1; step();
    R4out = 1; MUL = 1; Zin = 1; step();
    check("mul_180", outp, 64'd180);
    Zlowout = 1; LOin = 1; step();
    check("lo_180", dut.lo_q, 64'd180);
    Zhiout = 1; HIin = 1; step();
    check("hi_0", dut.hi_q, 64'd0);

    run_alu(6, 32'hFFFFFFFD, 32'd7);
    check("mul_neg", outp, 64'hFFFFFFFFFFFFFFEB);
    run_alu(11, 32'h80000001, 32'd1);
    check("rol", outp, 64'h3);
    run_alu(8, 32'h80000001, 32'd1);
    check("shr", outp, 64'h40000000);
    run_alu(5, 32'h80000001, 32'd1);
    check("sub", outp, 64'h80000000);
    run_alu(12, 32'h80000001, 32'd5);
    check("neg", outp, 64'hFFFFFFFB);
`ifdef DIV_EN
    run_alu(7, 32'd17, 32'd5);
    check("div_17_5", outp, {32'd2, 32'd3});
    run_alu(7, 32'd17, 32'd0);
    check("div_by_0", outp, {32'd17, 32'hFFFFFFFF});
`else
    run_alu(7, 32'd17, 32'd5);
    check("div_off", outp, 64'd5);
`endif

    // Clear overrides every enable, without needing a clock edge.
    {PCout, MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, IncPC, Read, R5in, R2in, R4in} = '1;
    Mdatain = 32'hDEADBEEF;
    Clear = 1'b1;
    #1;
    check("clr_outp", outp, 64'd0);
    check("clr_r2", dut.r2_q, 64'd0);
    check("clr_mdr", dut.mdr_q, 64'd0);
    @(posedge Clock); #1;
    check("clr_hold_pc", dut.pc_q, 64'd0);
    check("clr_hold_ir", dut.ir_q, 64'd0);
    check("clr_hold_z", outp, 64'd0);
    Clear = 1'b0;
    clr_ctl();

    for (int i = 0; i < 40; i++) begin
      a_r = $urandom;
      b_r = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      op_r = $urandom_range(0, 13);
      if (op_r == 7 && a_r == 32'h80000000 && b_r == 32'hFFFFFFFF) b_r = 32'd3;
      run_alu(op_r, a_r, b_r);
      check($sformatf("alu_op%0d", op_r), outp, alu_ref(op_r, a_r, b_r));
    end

    // Bus priority: preload every bus source with distinct random values.
    src[1] = $urandom; load_mdr(src[1]); MDRout = 1; PCin = 1; step();
    src[4] = $urandom; load_mdr(src[4]); MDRout = 1; HIin = 1; step();
    src[5] = $urandom; load_mdr(src[5]); MDRout = 1; LOin = 1; step();
    src[6] = $urandom; load_mdr(src[6]); MDRout = 1; R2in = 1; step();
    src[7] = $urandom; load_mdr(src[7]); MDRout = 1; R4in = 1; step();
    a_r = $urandom; b_r = $urandom;
    run_alu(6, a_r, b_r);
    z_m = alu_ref(6, a_r, b_r);
    src[0] = b_r;
    for (int i = 0; i < 30; i++) begin
      mask = 8'($urandom);
      src[2] = z_m[31:0];
      src[3] = z_m[63:32];
      bus_m = 32'd0;
      for (int k = 7; k >= 0; k--) if (mask[k]) bus_m = src[k];
      {R4out, R2out, LOout, HIout, Zhiout, Zlowout, PCout, MDRout} = mask;
      Zin = 1;
      step();
      z_m = {32'd0, bus_m};
      check($sformatf("bus_pri_%02h", mask), outp, z_m);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
